// File: rtl/store_buffer.sv
// store_buffer: write buffer between the MEM stage and the byte-enabled
// data memory. Stores are queued in a circular FIFO and retired one per
// cycle whenever the memory port is not needed by a load. Loads whose word
// overlaps any pending store stall until that store has drained.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  output logic        st_ready,
  output logic        st_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        sb_empty,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic [2:0]  mem_funct3
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [31:0]   ent_addr [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [2:0]    ent_f3   [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic          hit;
  logic          load_go;
  logic [AW-1:0] off;

  // Alignment / width legality of the presented store
  always_comb begin
    legal = 1'b0;
    case (st_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~st_addr[0];
      3'b010:  legal = (st_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Word-granular overlap of the load against every occupied entry
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // entry i is occupied when its distance from head is below count
      off = AW'(i) - head;
      if (({1'b0, off} < count) && (ent_addr[i][31:2] == ld_addr[31:2]))
        hit = 1'b1;
    end
  end

  assign st_ready = (count < FULL);
  assign sb_empty = (count == '0);
  assign ld_stall = ld_valid & hit;
  assign load_go  = ld_valid & ~hit;
  assign accept   = st_valid & st_ready;
  assign push     = accept & legal;
  assign pop      = ~load_go & (count != '0);

  // Memory port arbitration: unstalled load first, then drain, else idle
  always_comb begin
    mem_WE     = 1'b0;
    mem_A      = ld_addr;
    mem_WD     = '0;
    mem_funct3 = 3'b010;
    if (!load_go && (count != '0)) begin
      mem_WE     = 1'b1;
      mem_A      = ent_addr[head];
      mem_WD     = ent_data[head];
      mem_funct3 = ent_f3[head];
    end
  end

  // Entry storage; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
      ent_f3[tail]   <= st_funct3;
    end
  end

  // Pointers, occupancy and the registered error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      st_err <= 1'b0;
    end else begin
      st_err <= accept & ~legal;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_ready;
  logic        st_err;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        sb_empty;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [2:0]  mem_funct3;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_funct3(st_funct3), .st_ready(st_ready), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .sb_empty(sb_empty), .mem_WE(mem_WE), .mem_A(mem_A),
    .mem_WD(mem_WD), .mem_funct3(mem_funct3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;

  ent_t        q[$];
  logic [31:0] wlog_a[$];
  logic        exp_err;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_store(input logic [31:0] a, input logic [2:0] f);
    if (f == 3'd0) return 1'b1;
    if (f == 3'd1) return (a % 2) == 0;
    if (f == 3'd2) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    foreach (q[i]) if ((q[i].a >> 2) == (ld_addr >> 2)) return ld_valid;
    return 1'b0;
  endfunction

  function automatic bit model_we();
    return !(ld_valid && !model_stall()) && (q.size() > 0);
  endfunction

  // Expected combinational outputs from the model and current inputs
  task automatic compare();
    bit go;
    go = ld_valid && !model_stall();
    chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
    chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
    chk("ld_stall", 32'(ld_stall), 32'(model_stall()));
    chk("st_err",   32'(st_err),   32'(exp_err));
    chk("mem_WE",   32'(mem_WE),   32'(model_we()));
    if (model_we()) begin
      chk("mem_A",  mem_A,  q[0].a);
      chk("mem_WD", mem_WD, q[0].d);
      chk("mem_f3", 32'(mem_funct3), 32'(q[0].f));
    end else begin
      chk("mem_A",  mem_A,  ld_addr);
      chk("mem_f3", 32'(mem_funct3), 32'd2);
      if (!go) chk("mem_WD", mem_WD, 32'd0);
    end
  endtask

  task automatic put(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                     input logic [2:0] sf, input logic lv, input logic [31:0] la);
    st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf;
    ld_valid = lv; ld_addr = la;
    if (!rst_n) begin
      q.delete();
      exp_err = 1'b0;
    end
    #1;
    compare();
  endtask

  task automatic tick();
    bit acc;
    bit we;
    @(posedge clk);
    if (rst_n) begin
      acc = st_valid && (q.size() < DEPTH);
      we  = model_we();
      if (we) begin
        wlog_a.push_back(q[0].a);
        void'(q.pop_front());
      end
      if (acc && legal_store(st_addr, st_funct3))
        q.push_back('{a: st_addr, d: st_data, f: st_funct3});
      exp_err = acc && !legal_store(st_addr, st_funct3);
    end else begin
      exp_err = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    put(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);

    // Reset state
    idle();
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_stall", 32'(ld_stall), 32'd0);
    chk("rst_we",    32'(mem_WE),   32'd0);
    tick();
    rst_n = 1'b1;

    // Single word store, written one cycle after accept
    put(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 32'd0);
    chk("sw_ready", 32'(st_ready), 32'd1);
    tick();
    idle();
    chk("sw_we", 32'(mem_WE), 32'd1);
    chk("sw_a",  mem_A, 32'h100);
    chk("sw_wd", mem_WD, 32'hDEADBEEF);
    chk("sw_f3", 32'(mem_funct3), 32'd2);
    tick();
    idle();
    chk("sw_empty", 32'(sb_empty), 32'd1);
    tick();

    // Fill with loads holding the port, then FIFO-order drain
    wlog_a.delete();
    for (int k = 0; k <= DEPTH; k++) begin
      put(1'b1, 32'h300 + 32'(k), 32'(k), 3'b000, 1'b1, 32'h800);
      chk("fill_ready", 32'(st_ready), 32'(k < DEPTH));
      chk("fill_we", 32'(mem_WE), 32'd0);
      tick();
    end
    for (int k = 0; k < DEPTH; k++) begin
      idle();
      chk("drain_we", 32'(mem_WE), 32'd1);
      chk("drain_a", mem_A, 32'h300 + 32'(k));
      tick();
    end
    idle();
    chk("drain_empty", 32'(sb_empty), 32'd1);
    chk("drain_cnt", 32'(wlog_a.size()), 32'(DEPTH));
    tick();

    // Load hazard against a pending halfword store
    put(1'b1, 32'h202, 32'h0000BEEF, 3'b001, 1'b0, 32'd0);
    tick();
    put(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h200);
    chk("haz_stall", 32'(ld_stall), 32'd1);
    chk("haz_we", 32'(mem_WE), 32'd1);
    chk("haz_a", mem_A, 32'h202);
    tick();
    put(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h200);
    chk("haz_rel", 32'(ld_stall), 32'd0);
    chk("haz_ld_a", mem_A, 32'h200);
    chk("haz_ld_we", 32'(mem_WE), 32'd0);
    tick();

    // Misaligned stores are consumed and flagged, never written
    put(1'b1, 32'h103, 32'h1, 3'b010, 1'b0, 32'd0);
    tick();
    put(1'b1, 32'h105, 32'h2, 3'b001, 1'b0, 32'd0);
    chk("mis_err1", 32'(st_err), 32'd1);
    chk("mis_empty1", 32'(sb_empty), 32'd1);
    tick();
    idle();
    chk("mis_err2", 32'(st_err), 32'd1);
    chk("mis_we", 32'(mem_WE), 32'd0);
    chk("mis_empty2", 32'(sb_empty), 32'd1);
    tick();
    idle();
    chk("mis_err_off", 32'(st_err), 32'd0);
    tick();

    // Simultaneous push and pop at count 2, across the pointer wrap
    put(1'b1, 32'h400, 32'h11, 3'b010, 1'b1, 32'h900);
    tick();
    put(1'b1, 32'h404, 32'h22, 3'b010, 1'b1, 32'h900);
    tick();
    for (int k = 0; k < 6; k++) begin
      put(1'b1, 32'h408 + 32'(4 * k), 32'h33 + 32'(k), 3'b010, 1'b0, 32'd0);
      chk("pp_ready", 32'(st_ready), 32'd1);
      chk("pp_we", 32'(mem_WE), 32'd1);
      chk("pp_a", mem_A, (k < 2) ? 32'h400 + 32'(4 * k) : 32'h408 + 32'(4 * (k - 2)));
      tick();
      chk("pp_count", 32'(q.size()), 32'd2);
    end
    idle(); tick();
    idle(); tick();
    idle();
    chk("pp_empty", 32'(sb_empty), 32'd1);
    tick();

    // Reset in the middle of a drain
    for (int k = 0; k < 3; k++) begin
      put(1'b1, 32'h500 + 32'(4 * k), 32'hA0 + 32'(k), 3'b010, 1'b1, 32'h900);
      tick();
    end
    idle();
    chk("rd_we", 32'(mem_WE), 32'd1);
    chk("rd_a", mem_A, 32'h500);
    tick();
    rst_n = 1'b0;
    idle();
    chk("rd_rst_we", 32'(mem_WE), 32'd0);
    chk("rd_rst_empty", 32'(sb_empty), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("rd_no_stale", 32'(mem_WE), 32'd0);
      chk("rd_empty", 32'(sb_empty), 32'd1);
      tick();
    end

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] f;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) f = 3'd0;
      else if (r < 6) f = 3'd1;
      else if (r < 8) f = 3'd2;
      else f = 3'($urandom_range(3, 7));
      rst_n = ($urandom_range(0, 299) != 0);
      put(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 31)), $urandom, f,
          1'($urandom_range(0, 2) == 0), 32'h1000 + 32'($urandom_range(0, 31)));
      tick();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write buffer between the MEM pipeline stage and the byte-enabled data memory. Stores from the pipeline are queued here and retired to memory one per cycle, so they do not occupy the memory port while a load needs it. The block owns the data memory's single address port: it drives either the current load address (read) or the oldest buffered store (write). Loads that overlap a pending store are stalled until that store has drained.

## Interface
- DEPTH, 4: number of store entries; power of two, 2..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_addr  in  32  store byte address.
- st_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- st_funct3  in  3  store width: 000 byte, 001 half, 010 word.
- st_ready  out  1  entry available; the store is accepted when st_valid && st_ready.
- st_err  out  1  one-cycle pulse: an accepted store was misaligned or had an illegal funct3.
- ld_valid  in  1  MEM stage issues a load this cycle.
- ld_addr  in  32  load byte address.
- ld_stall  out  1  load must hold: it overlaps a buffered store.
- sb_empty  out  1  no stores pending (used by fence and drain-before-halt).
- mem_WE  out  1  write enable to data memory.
- mem_A  out  32  data memory address.
- mem_WD  out  32  data memory write data.
- mem_funct3  out  3  data memory width code.

## Operation
- Circular FIFO with head/tail pointers of width log2(DEPTH) and a count of width log2(DEPTH)+1. Each entry holds {addr, data, funct3}.
- Alignment check on accept:
  - byte: any address is legal.
  - half: legal only if addr[0] = 0.
  - word: legal only if addr[1:0] = 00.
  - funct3 values other than 000/001/010 are illegal.
  - An illegal store is consumed (st_ready handshake completes), not enqueued, and st_err pulses on the next cycle.
- st_ready = (count < DEPTH). It is not raised by a pop in the same cycle; there is no pass-through.
- Overlap check: ld_stall = ld_valid && any valid entry has addr[31:2] == ld_addr[31:2]. This is a word-granular conservative match.
- Port arbitration (combinational, with load_go = ld_valid && !ld_stall):
  - If load_go: mem_A = ld_addr, mem_WE = 0, mem_funct3 = 010, and no drain this cycle.
  - Else if count > 0: drive the head entry with mem_A = addr, mem_WD = data, mem_funct3 = funct3, mem_WE = 1. Pop at the clock edge.
  - Else (idle): mem_WE = 0, mem_A = ld_addr, mem_WD = 0, mem_funct3 = 010.
- Deadlock freedom: a stalled load never blocks draining, so the conflicting entry always retires.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- sb_empty = (count == 0).

## Timing
- Reset (asynchronous, rst_n low): count, head and tail = 0; st_err = 0; entry storage is not cleared. Resulting outputs: st_ready = 1, sb_empty = 1, ld_stall = 0, mem_WE = 0.
- Reset asserted mid-operation discards all pending stores immediately.
- Latency: an accepted legal store is visible at the head no earlier than the next cycle. With an empty buffer and no loads, the earliest write to memory is one cycle after accept (at the second rising edge after st_valid).
- ld_stall, st_ready and all mem_* outputs are combinational from registered state and the current inputs. st_err is registered.
- A load stalled on an entry is released in the cycle after that entry's write edge. On that cycle the load reads the updated data.
- Throughput: one retire per cycle when there are no loads. Loads take priority over draining unless they are stalled.

## Test plan
- Reset then word store: SW 0xDEADBEEF to 0x100 with no loads. Required: st_ready = 1; next cycle mem_WE = 1, mem_A = 0x100, mem_WD = 0xDEADBEEF, mem_funct3 = 010; then sb_empty = 1.
- Fill: DEPTH+1 back-to-back SB with ld_valid held high to non-overlapping addresses. Required: st_ready falls after DEPTH accepts; no mem_WE while loads proceed; after loads stop, entries drain in FIFO order, one per cycle.
- Load hazard: SH 0xBEEF to 0x202, then LW at 0x200 next cycle. Required: ld_stall = 1 and mem_WE = 1 with mem_A = 0x202; the following cycle ld_stall = 0 and mem_A = 0x200.
- Misaligned: SW to 0x103, then SH to 0x105. Required: st_err pulses for each on the next cycle; nothing is written; sb_empty stays 1.
- Simultaneous push/pop with count = 2: a store is accepted while the head drains. Required: count stays 2; pointers wrap correctly across the DEPTH boundary.
- Reset mid-drain with 3 entries: assert rst_n = 0. Required: mem_WE = 0 immediately; after release sb_empty = 1 and no stale writes occur.
